mixed_width_dp_ram: RTL and testbench

- Simple dual-port RAM: one write port, one registered read port.
- The write and read ports may have different data widths (WW, RW), related by a power-of-2 ratio.
- In the vocoder datapath it buffers IFFT output samples for rate-decoupled readback.
- It is also the generic frame/sample buffer used elsewhere in the FPGA design.

---
 rtl/ram_pkg.sv | 33 +++
 rtl/mixed_width_dp_ram.sv | 79 +++++++
 tb/tb_mixed_width_dp_ram.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/ram_pkg.sv
// Shared sizing helpers for the RAM and sample buffers.
// Width ratios between ports are always powers of two.
package ram_pkg;

  function automatic int unsigned ram_clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = (v > 0) ? v - 1 : 0;
    while (x != 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic int unsigned width_ratio(input int unsigned a, input int unsigned b);
    return (a > b) ? a / b : b / a;
  endfunction

  function automatic int unsigned row_width(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic int unsigned lane_bits(input int unsigned a, input int unsigned b);
    return ram_clog2(width_ratio(a, b));
  endfunction

endpackage

// File: rtl/mixed_width_dp_ram.sv
// Simple dual-port RAM with independent write/read widths (power-of-2 ratio).
// Rows are max(WW,RW) wide; the narrow port's low address bits select the lane.
module mixed_width_dp_ram
  import ram_pkg::*;
#(
  parameter int unsigned WORDS = 1024,
  parameter int unsigned WW    = 27,
  parameter int unsigned RW    = 27,
  localparam int unsigned RWORDS = WORDS * WW / RW,
  localparam int unsigned WAW    = ram_clog2(WORDS),
  localparam int unsigned RAW    = ram_clog2(RWORDS)
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           we,
  input  logic [WAW-1:0] waddr,
  input  logic [WW-1:0]  wdata,
  input  logic [RAW-1:0] raddr,
  output logic [RW-1:0]  q
);

  localparam int unsigned MW   = row_width(WW, RW);
  localparam int unsigned LB   = lane_bits(WW, RW);
  localparam int unsigned ROWS = (WORDS * WW) / MW;

  if (!is_pow2(WORDS) || (WORDS < 2)) begin : g_chk_words
    $fatal(1, "mixed_width_dp_ram: WORDS must be a power of 2 and >= 2");
  end
  if (!is_pow2(width_ratio(WW, RW)) || ((WW % RW) != 0 && (RW % WW) != 0)) begin : g_chk_ratio
    $fatal(1, "mixed_width_dp_ram: WW/RW ratio must be a power of 2");
  end
  if (((WW * WORDS) % RW) != 0 || (RWORDS < 2)) begin : g_chk_depth
    $fatal(1, "mixed_width_dp_ram: WW*WORDS must divide into at least two RW words");
  end

  logic          wr_en;
  logic [RW-1:0] rd_d;
  logic [RW-1:0] q_q;
  logic [MW-1:0] mem_q [ROWS] = '{default: '0};

  // Writes are ignored while reset is held; the array itself is never reset.
  assign wr_en = we & reset_n;

  if (RW == WW) begin : g_equal
    always_ff @(posedge clk) begin
      if (wr_en) mem_q[waddr] <= wdata;
    end
    assign rd_d = mem_q[raddr];
  end else if (RW < WW) begin : g_wide_wr
    logic [RAW-LB-1:0] rrow;
    logic [LB-1:0]     rlane;
    assign rrow  = raddr[RAW-1:LB];
    assign rlane = raddr[LB-1:0];

    always_ff @(posedge clk) begin
      if (wr_en) mem_q[waddr] <= wdata;
    end
    assign rd_d = mem_q[rrow][rlane*RW +: RW];
  end else begin : g_wide_rd
    logic [WAW-LB-1:0] wrow;
    logic [LB-1:0]     wlane;
    assign wrow  = waddr[WAW-1:LB];
    assign wlane = waddr[LB-1:0];

    always_ff @(posedge clk) begin
      if (wr_en) mem_q[wrow][wlane*WW +: WW] <= wdata;
    end
    assign rd_d = mem_q[raddr];
  end

  // Read-first: the output register samples the array before this edge's write lands.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) q_q <= '0;
    else          q_q <= rd_d;
  end

  assign q = q_q;

endmodule

// File: tb/tb_mixed_width_dp_ram.sv
// Bench for mixed_width_dp_ram: equal, wide-write and wide-read configurations.
module tb_mixed_width_dp_ram;

  logic clk;
  logic rst_n;

  logic        we0;
  logic [9:0]  waddr0;
  logic [26:0] wdata0;
  logic [9:0]  raddr0;
  logic [26:0] q0;

  logic        we1;
  logic [7:0]  waddr1;
  logic [31:0] wdata1;
  logic [9:0]  raddr1;
  logic [7:0]  q1;

  logic        we2;
  logic [9:0]  waddr2;
  logic [7:0]  wdata2;
  logic [7:0]  raddr2;
  logic [31:0] q2;

  int n_checks = 0;
  int n_errors = 0;

  mixed_width_dp_ram u0 (
    .clk(clk), .reset_n(rst_n), .we(we0), .waddr(waddr0),
    .wdata(wdata0), .raddr(raddr0), .q(q0)
  );

  mixed_width_dp_ram #(.WORDS(256), .WW(32), .RW(8)) u1 (
    .clk(clk), .reset_n(rst_n), .we(we1), .waddr(waddr1),
    .wdata(wdata1), .raddr(raddr1), .q(q1)
  );

  mixed_width_dp_ram #(.WORDS(1024), .WW(8), .RW(32)) u2 (
    .clk(clk), .reset_n(rst_n), .we(we2), .waddr(waddr2),
    .wdata(wdata2), .raddr(raddr2), .q(q2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [26:0] exp;
    string       tag;
  } sb_t;

  typedef struct {
    bit          we;
    logic [9:0]  waddr;
    logic [26:0] wdata;
    logic [9:0]  raddr;
    bit          chk;
    logic [26:0] exp;
  } vec_t;

  sb_t  sb_q[$];
  sb_t  sb_e;
  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [26:0] exp, input string tag);
    sb_t e;
    e.exp = exp;
    e.tag = tag;
    sb_q.push_back(e);
  endtask

  // Expectations are pushed on the negedge that drives raddr0 and retired one edge later.
  always @(posedge clk) begin
    #1;
    if (sb_q.size() != 0) begin
      sb_e = sb_q.pop_front();
      chk(sb_e.tag, 64'(q0), 64'(sb_e.exp));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] word;
    logic [7:0]  bytes_w [4];

    rst_n = 1'b0;
    we0 = 1'b0; waddr0 = '0; wdata0 = '0; raddr0 = '0;
    we1 = 1'b0; waddr1 = '0; wdata1 = '0; raddr1 = '0;
    we2 = 1'b0; waddr2 = '0; wdata2 = '0; raddr2 = '0;

    vecs[0] = '{1'b1, 10'd7,    27'h5A5A5A0, 10'd0,    1'b0, 27'h0};
    vecs[1] = '{1'b0, 10'd0,    27'h0,       10'd7,    1'b1, 27'h5A5A5A0};
    vecs[2] = '{1'b1, 10'd3,    27'h1,       10'd0,    1'b0, 27'h0};
    vecs[3] = '{1'b1, 10'd3,    27'h2,       10'd3,    1'b1, 27'h1};
    vecs[4] = '{1'b0, 10'd0,    27'h0,       10'd3,    1'b1, 27'h2};
    vecs[5] = '{1'b1, 10'd1023, 27'h0ABCDEF, 10'd0,    1'b0, 27'h0};
    vecs[6] = '{1'b1, 10'd0,    27'h1234567, 10'd0,    1'b1, 27'h0};
    vecs[7] = '{1'b0, 10'd0,    27'h0,       10'd1023, 1'b1, 27'h0ABCDEF};
    vecs[8] = '{1'b0, 10'd0,    27'h0,       10'd0,    1'b1, 27'h1234567};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_q0", 64'(q0), 64'h0);
    chk("reset_q1", 64'(q1), 64'h0);
    chk("reset_q2", 64'(q2), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      we0 = vecs[i].we; waddr0 = vecs[i].waddr;
      wdata0 = vecs[i].wdata; raddr0 = vecs[i].raddr;
      if (vecs[i].chk) push(vecs[i].exp, $sformatf("vec%0d", i));
    end
    @(negedge clk);
    we0 = 1'b0;

    // Write address i while reading back address i-1.
    for (int i = 0; i <= 1024; i++) begin
      @(negedge clk);
      we0    = (i < 1024);
      waddr0 = i[9:0];
      wdata0 = 27'(i) ^ 27'h3FF;
      raddr0 = 10'(i - 1);
      if (i > 0) push(27'(i - 1) ^ 27'h3FF, $sformatf("sweep%0d", i - 1));
    end

    @(negedge clk);
    we0 = 1'b1; waddr0 = 10'd0; wdata0 = 27'h7FFFFFF; raddr0 = 10'd5;
    @(negedge clk);
    we0 = 1'b0; raddr0 = 10'd0;
    push(27'h7FFFFFF, "pre_reset_read");
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("reset_async_q0", 64'(q0), 64'h0);
    @(negedge clk);
    we0 = 1'b1; waddr0 = 10'd1; wdata0 = 27'h5555555; raddr0 = 10'd1;
    @(posedge clk);
    #1;
    chk("reset_hold_q0", 64'(q0), 64'h0);
    @(negedge clk);
    we0 = 1'b0;
    rst_n = 1'b1;
    push(27'h3FE, "reset_write_ignored");
    @(negedge clk);
    raddr0 = 10'd0;
    push(27'h7FFFFFF, "reset_contents_kept");

    word = 32'hDDCCBBAA;
    @(negedge clk);
    we1 = 1'b1; waddr1 = 8'd5; wdata1 = word;
    @(negedge clk);
    we1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      raddr1 = 10'(20 + k);
      @(posedge clk);
      #1;
      chk($sformatf("narrow_read_lane%0d", k), 64'(q1), 64'(word[k*8 +: 8]));
    end

    bytes_w[0] = 8'h11; bytes_w[1] = 8'h22; bytes_w[2] = 8'h33; bytes_w[3] = 8'h44;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      we2 = 1'b1; waddr2 = 10'(8 + k); wdata2 = bytes_w[k];
    end
    @(negedge clk);
    we2 = 1'b0; raddr2 = 8'd2;
    @(posedge clk);
    #1;
    chk("wide_read_pack", 64'(q2), 64'h44332211);
    @(negedge clk);
    we2 = 1'b1; waddr2 = 10'd9; wdata2 = 8'hFF;
    @(negedge clk);
    we2 = 1'b0;
    @(posedge clk);
    #1;
    chk("wide_read_lane_keep", 64'(q2), 64'h4433FF11);
    @(negedge clk);
    we2 = 1'b1; waddr2 = 10'd8; wdata2 = 8'hAA;
    @(posedge clk);
    #1;
    chk("wide_read_rdw_old", 64'(q2), 64'h4433FF11);
    @(negedge clk);
    we2 = 1'b0;
    @(posedge clk);
    #1;
    chk("wide_read_rdw_new", 64'(q2), 64'h4433FFAA);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(sb_q.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
